// File: rtl/fase_noite_pkg.sv
// rtl/fase_noite_pkg.sv - shared role codes, state encodings and helpers for the night engine
package fase_noite_pkg;

  localparam int NJ = 5;

  localparam logic [1:0] ALDEAO = 2'b00;
  localparam logic [1:0] LOBO   = 2'b01;
  localparam logic [1:0] MEDICO = 2'b10;

  localparam logic [2:0] NENHUM = 3'd7;

  typedef enum logic [2:0] {
    OCIOSO        = 3'd0,
    ESPERA_LOBO   = 3'd1,
    ESPERA_MEDICO = 3'd2,
    RESOLVE       = 3'd3,
    VERIFICA      = 3'd4,
    FIM           = 3'd5
  } estado_t;

  // Indices 5..7 (including NENHUM) read as dead, so callers need no range check.
  function automatic logic esta_vivo(input logic [4:0] vivos, input logic [2:0] idx);
    logic [7:0] estendido;
    estendido = {3'b000, vivos};
    return estendido[idx];
  endfunction

  function automatic logic [2:0] conta_vivos(input logic [4:0] vivos);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 5; i++) begin
      n = n + {2'b00, vivos[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/fase_noite_decodifica_papeis.sv
// rtl/fase_noite_decodifica_papeis.sv - role vector to wolf and doctor index, lowest index wins
module decodifica_papeis
  import fase_noite_pkg::*;
(
  input  logic [9:0] papeis_i,
  output logic [2:0] lobo_o,
  output logic [2:0] medico_o
);

  // Scanning from the top index down lets the lowest matching player overwrite last.
  always_comb begin
    lobo_o   = NENHUM;
    medico_o = NENHUM;
    for (int i = NJ - 1; i >= 0; i--) begin
      if (papeis_i[9 - 2*i -: 2] == LOBO) begin
        lobo_o = 3'(i);
      end
      if (papeis_i[9 - 2*i -: 2] == MEDICO) begin
        medico_o = 3'(i);
      end
    end
  end

endmodule

// File: rtl/fase_noite.sv
// rtl/fase_noite.sv - night-phase engine: victim/protection handshake, death resolution, victory flags
module fase_noite #(
  parameter int NJ = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       carrega,
  input  logic [9:0] jogo_atual,
  input  logic       inicia_noite,
  input  logic [2:0] escolha,
  input  logic       confirma,
  output logic [4:0] vivos,
  output logic [2:0] morto_noite,
  output logic       fim_noite,
  output logic       erro_escolha,
  output logic       espera_lobo,
  output logic       espera_medico,
  output logic       vitoria_lobo,
  output logic       vitoria_aldeia,
  output logic [3:0] noites,
  output logic [3:0] db_estado
);
  import fase_noite_pkg::*;

  localparam logic [4:0] TODOS_VIVOS = 5'((1 << NJ) - 1);

  estado_t    estado_q;
  logic [9:0] papeis_q;
  logic [4:0] vivos_q;
  logic [2:0] morto_q;
  logic [2:0] vitima_q;
  logic [2:0] protegido_q;
  logic [3:0] noites_q;
  logic       fim_q;
  logic       erro_q;
  logic       vit_lobo_q;
  logic       vit_aldeia_q;

  logic [2:0] lobo_idx;
  logic [2:0] medico_idx;
  logic       lobo_vivo;
  logic       medico_vivo;
  logic [7:0] mascara_vitima;

  decodifica_papeis u_papeis (
    .papeis_i (papeis_q),
    .lobo_o   (lobo_idx),
    .medico_o (medico_idx)
  );

  always_comb begin
    lobo_vivo      = esta_vivo(vivos_q, lobo_idx);
    medico_vivo    = esta_vivo(vivos_q, medico_idx);
    mascara_vitima = 8'b0000_0001 << vitima_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q     <= OCIOSO;
      papeis_q     <= 10'b0;
      vivos_q      <= TODOS_VIVOS;
      morto_q      <= NENHUM;
      vitima_q     <= NENHUM;
      protegido_q  <= NENHUM;
      noites_q     <= 4'd0;
      fim_q        <= 1'b0;
      erro_q       <= 1'b0;
      vit_lobo_q   <= 1'b0;
      vit_aldeia_q <= 1'b0;
    end else if (carrega) begin
      estado_q     <= OCIOSO;
      papeis_q     <= jogo_atual;
      vivos_q      <= TODOS_VIVOS;
      morto_q      <= NENHUM;
      vitima_q     <= NENHUM;
      protegido_q  <= NENHUM;
      noites_q     <= 4'd0;
      fim_q        <= 1'b0;
      erro_q       <= 1'b0;
      vit_lobo_q   <= 1'b0;
      vit_aldeia_q <= 1'b0;
    end else begin
      fim_q  <= 1'b0;
      erro_q <= 1'b0;
      case (estado_q)
        OCIOSO: begin
          if (inicia_noite && !vit_lobo_q && !vit_aldeia_q) begin
            estado_q <= lobo_vivo ? ESPERA_LOBO : VERIFICA;
          end
        end
        ESPERA_LOBO: begin
          if (confirma) begin
            if (esta_vivo(vivos_q, escolha) && (escolha != lobo_idx)) begin
              vitima_q <= escolha;
              if (medico_vivo) begin
                estado_q <= ESPERA_MEDICO;
              end else begin
                protegido_q <= NENHUM;
                estado_q    <= RESOLVE;
              end
            end else begin
              erro_q <= 1'b1;
            end
          end
        end
        ESPERA_MEDICO: begin
          if (confirma) begin
            if (esta_vivo(vivos_q, escolha)) begin
              protegido_q <= escolha;
              estado_q    <= RESOLVE;
            end else begin
              erro_q <= 1'b1;
            end
          end
        end
        RESOLVE: begin
          if (vitima_q != protegido_q) begin
            vivos_q <= vivos_q & ~mascara_vitima[4:0];
            morto_q <= vitima_q;
          end else begin
            morto_q <= NENHUM;
          end
          if (noites_q != 4'hF) begin
            noites_q <= noites_q + 4'd1;
          end
          estado_q <= VERIFICA;
        end
        VERIFICA: begin
          if (!lobo_vivo) begin
            vit_aldeia_q <= 1'b1;
          end else if (conta_vivos(vivos_q) <= 3'd2) begin
            vit_lobo_q <= 1'b1;
          end
          // Raised here so the pulse coincides with the FIM state itself.
          fim_q    <= 1'b1;
          estado_q <= FIM;
        end
        FIM: begin
          estado_q <= OCIOSO;
        end
        default: begin
          estado_q <= OCIOSO;
        end
      endcase
    end
  end

  always_comb begin
    case (estado_q)
      OCIOSO, ESPERA_LOBO, ESPERA_MEDICO, RESOLVE, VERIFICA, FIM:
        db_estado = {1'b0, estado_q};
      default:
        db_estado = 4'b1111;
    endcase
  end

  assign vivos          = vivos_q;
  assign morto_noite    = morto_q;
  assign fim_noite      = fim_q;
  assign erro_escolha   = erro_q;
  assign espera_lobo    = (estado_q == ESPERA_LOBO);
  assign espera_medico  = (estado_q == ESPERA_MEDICO);
  assign vitoria_lobo   = vit_lobo_q;
  assign vitoria_aldeia = vit_aldeia_q;
  assign noites         = noites_q;

endmodule

// File: tb/tb_fase_noite.sv
// tb/tb_fase_noite.sv - table-driven and scoreboard checks for the night engine
module tb_fase_noite;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       carrega = 1'b0;
  logic [9:0] jogo_atual = 10'b0;
  logic       inicia_noite = 1'b0;
  logic [2:0] escolha = 3'd0;
  logic       confirma = 1'b0;
  logic [4:0] vivos;
  logic [2:0] morto_noite;
  logic       fim_noite;
  logic       erro_escolha;
  logic       espera_lobo;
  logic       espera_medico;
  logic       vitoria_lobo;
  logic       vitoria_aldeia;
  logic [3:0] noites;
  logic [3:0] db_estado;

  fase_noite #(.NJ(5)) dut (
    .clock          (clock),
    .reset          (reset),
    .carrega        (carrega),
    .jogo_atual     (jogo_atual),
    .inicia_noite   (inicia_noite),
    .escolha        (escolha),
    .confirma       (confirma),
    .vivos          (vivos),
    .morto_noite    (morto_noite),
    .fim_noite      (fim_noite),
    .erro_escolha   (erro_escolha),
    .espera_lobo    (espera_lobo),
    .espera_medico  (espera_medico),
    .vitoria_lobo   (vitoria_lobo),
    .vitoria_aldeia (vitoria_aldeia),
    .noites         (noites),
    .db_estado      (db_estado)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int fim_count = 0;
  int cnt_medico = 0;

  typedef struct {
    logic [4:0] vivos;
    logic [2:0] morto;
    logic [3:0] noites;
    logic       vl;
    logic       va;
    int         cyc;
  } esp_t;

  esp_t sb[$];

  typedef struct {
    logic [9:0] jogo;
    bit         tem_lobo;
    bit         tem_med;
    logic [2:0] lp;
    logic [2:0] mp;
    logic [4:0] ev;
    logic [2:0] em;
    logic       va;
    logic       vl;
  } vet_t;

  vet_t tab[6];

  task automatic chk(input string nome, input int actual, input int expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nome, cyc, actual, expected);
    end
  endtask

  always @(negedge clock) begin
    esp_t e;
    if (reset) begin
      if (espera_medico) cnt_medico++;
      if (espera_lobo && espera_medico) begin
        n_vec++;
        n_err++;
        $display("FAIL espera_exclusiva at cycle %0d: both waits high", cyc);
      end
      if (fim_noite) begin
        fim_count++;
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL fim_inesperado at cycle %0d: got fim_noite 1, expected 0", cyc);
        end else begin
          e = sb.pop_front();
          chk("fim_ciclo", cyc, e.cyc);
          chk("fim_vivos", int'(vivos), int'(e.vivos));
          chk("fim_morto", int'(morto_noite), int'(e.morto));
          chk("fim_noites", int'(noites), int'(e.noites));
          chk("fim_vit_lobo", int'(vitoria_lobo), int'(e.vl));
          chk("fim_vit_aldeia", int'(vitoria_aldeia), int'(e.va));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic empurra(input logic [4:0] v, input logic [2:0] m, input logic [3:0] n,
                         input logic vl, input logic va, input int lat);
    esp_t e;
    e.vivos = v; e.morto = m; e.noites = n; e.vl = vl; e.va = va; e.cyc = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic carregar(input logic [9:0] j);
    jogo_atual = j;
    carrega = 1'b1;
    tick();
    carrega = 1'b0;
  endtask

  task automatic pulso_inicia();
    inicia_noite = 1'b1;
    tick();
    inicia_noite = 1'b0;
  endtask

  task automatic confirmar(input logic [2:0] e);
    escolha = e;
    confirma = 1'b1;
    tick();
    confirma = 1'b0;
  endtask

  task automatic aguarda_fim();
    int ini;
    int k;
    ini = fim_count;
    k = 0;
    while (fim_count == ini && k < 12) begin
      tick();
      k++;
    end
    if (fim_count == ini) begin
      n_vec++;
      n_err++;
      $display("FAIL fim_timeout at cycle %0d: got no fim_noite, expected one", cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog at cycle %0d: got no finish, expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int m0;
    int f0;

    tab[0] = '{10'b01_10_00_00_00, 1, 1, 3'd2, 3'd3, 5'b11011, 3'd2, 1'b0, 1'b0};
    tab[1] = '{10'b01_10_00_00_00, 1, 1, 3'd2, 3'd2, 5'b11111, 3'd7, 1'b0, 1'b0};
    tab[2] = '{10'b00_00_01_00_10, 1, 1, 3'd0, 3'd4, 5'b11110, 3'd0, 1'b0, 1'b0};
    tab[3] = '{10'b00_00_00_00_00, 0, 0, 3'd0, 3'd0, 5'b11111, 3'd7, 1'b1, 1'b0};
    tab[4] = '{10'b11_01_11_00_00, 1, 0, 3'd3, 3'd0, 5'b10111, 3'd3, 1'b0, 1'b0};
    tab[5] = '{10'b01_01_10_10_00, 1, 1, 3'd1, 3'd0, 5'b11101, 3'd1, 1'b0, 1'b0};

    tick();
    tick();
    chk("rst_estado", int'(db_estado), 0);
    chk("rst_vivos", int'(vivos), 5'b11111);
    chk("rst_morto", int'(morto_noite), 7);
    chk("rst_noites", int'(noites), 0);
    chk("rst_flags", int'({fim_noite, erro_escolha, vitoria_lobo, vitoria_aldeia, espera_lobo, espera_medico}), 0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      carregar(tab[i].jogo);
      chk("tab_ocioso", int'(db_estado), 0);
      if (!tab[i].tem_lobo) begin
        empurra(tab[i].ev, tab[i].em, 4'd0, tab[i].vl, tab[i].va, 2);
        pulso_inicia();
      end else begin
        pulso_inicia();
        chk("tab_espera_lobo", int'(espera_lobo), 1);
        if (!tab[i].tem_med) empurra(tab[i].ev, tab[i].em, 4'd1, tab[i].vl, tab[i].va, 3);
        confirmar(tab[i].lp);
        if (tab[i].tem_med) begin
          chk("tab_espera_medico", int'(espera_medico), 1);
          empurra(tab[i].ev, tab[i].em, 4'd1, tab[i].vl, tab[i].va, 3);
          confirmar(tab[i].mp);
        end
      end
      aguarda_fim();
      chk("tab_volta_ocioso", int'(db_estado), 0);
    end

    // Rejected confirms: wolf self, out of range, dead player; doctor out of range.
    carregar(10'b01_10_00_00_00);
    pulso_inicia();
    confirmar(3'd2);
    empurra(5'b11011, 3'd2, 4'd1, 1'b0, 1'b0, 3);
    confirmar(3'd3);
    aguarda_fim();
    pulso_inicia();
    confirmar(3'd0);
    chk("erro_lobo_self", int'(erro_escolha), 1);
    chk("erro_estado", int'(db_estado), 1);
    tick();
    chk("erro_um_ciclo", int'(erro_escolha), 0);
    confirmar(3'd6);
    chk("erro_lobo_6", int'(erro_escolha), 1);
    confirmar(3'd2);
    chk("erro_lobo_morto", int'(erro_escolha), 1);
    chk("erro_estado2", int'(db_estado), 1);
    confirmar(3'd3);
    chk("aceito_lobo", int'(erro_escolha), 0);
    chk("aceito_estado", int'(db_estado), 2);
    confirmar(3'd7);
    chk("erro_medico_7", int'(erro_escolha), 1);
    chk("erro_medico_estado", int'(db_estado), 2);
    empurra(5'b10011, 3'd3, 4'd2, 1'b0, 1'b0, 3);
    confirmar(3'd1);
    aguarda_fim();

    // Doctor killed on night 1, then medic wait skipped, then wolf victory.
    carregar(10'b01_10_00_00_00);
    pulso_inicia();
    confirmar(3'd1);
    empurra(5'b11101, 3'd1, 4'd1, 1'b0, 1'b0, 3);
    confirmar(3'd3);
    aguarda_fim();
    m0 = cnt_medico;
    pulso_inicia();
    empurra(5'b11001, 3'd2, 4'd2, 1'b0, 1'b0, 3);
    confirmar(3'd2);
    chk("pula_medico", int'(db_estado), 3);
    aguarda_fim();
    chk("medico_nunca", cnt_medico - m0, 0);
    pulso_inicia();
    empurra(5'b10001, 3'd3, 4'd3, 1'b1, 1'b0, 3);
    confirmar(3'd3);
    aguarda_fim();
    f0 = fim_count;
    pulso_inicia();
    tick();
    tick();
    chk("vitoria_ignora_inicia", int'(db_estado), 0);
    chk("vitoria_sem_fim", fim_count - f0, 0);
    chk("vitoria_lobo_fica", int'(vitoria_lobo), 1);
    carregar(10'b01_10_00_00_00);
    chk("carrega_vivos", int'(vivos), 5'b11111);
    chk("carrega_vl", int'(vitoria_lobo), 0);
    chk("carrega_noites", int'(noites), 0);
    chk("carrega_morto", int'(morto_noite), 7);

    // carrega mid ESPERA_MEDICO beats a simultaneous confirm.
    pulso_inicia();
    confirmar(3'd2);
    empurra(5'b11011, 3'd2, 4'd1, 1'b0, 1'b0, 3);
    confirmar(3'd4);
    aguarda_fim();
    pulso_inicia();
    confirmar(3'd3);
    chk("meio_medico", int'(espera_medico), 1);
    jogo_atual = 10'b0;
    escolha = 3'd3;
    confirma = 1'b1;
    carrega = 1'b1;
    tick();
    carrega = 1'b0;
    confirma = 1'b0;
    chk("carrega_meio_estado", int'(db_estado), 0);
    chk("carrega_meio_vivos", int'(vivos), 5'b11111);
    chk("carrega_meio_noites", int'(noites), 0);
    chk("carrega_meio_morto", int'(morto_noite), 7);
    empurra(5'b11111, 3'd7, 4'd0, 1'b0, 1'b1, 2);
    pulso_inicia();
    aguarda_fim();

    // Reset mid ESPERA_MEDICO wins over carrega, so roles clear to no wolf.
    carregar(10'b01_10_00_00_00);
    pulso_inicia();
    confirmar(3'd2);
    chk("meio_medico2", int'(espera_medico), 1);
    reset = 1'b0;
    carrega = 1'b1;
    jogo_atual = 10'b01_10_00_00_00;
    tick();
    reset = 1'b1;
    carrega = 1'b0;
    chk("reset_meio_estado", int'(db_estado), 0);
    chk("reset_meio_vivos", int'(vivos), 5'b11111);
    chk("reset_meio_flags", int'({espera_medico, vitoria_lobo, vitoria_aldeia, noites}), 0);
    empurra(5'b11111, 3'd7, 4'd0, 1'b0, 1'b1, 2);
    pulso_inicia();
    aguarda_fim();

    chk("sb_vazio", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
